// File: rtl/two_parallel_serializer.sv
// Two-parallel to single-rate serializer.
// Each accepted pair (y0, y1) is saturated to OUT_W bits and stored as one
// FIFO entry. The head entry is emitted y0 first, then y1, and is only
// released after y1 is taken.

// Per-lane saturation: clamp a signed IN_W sample into the signed OUT_W range.
module two_parallel_serializer_sat #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             clamp
);
  // Bits above the OUT_W sign bit must all equal it, else the value is out of range.
  logic [IN_W-OUT_W:0] upper;
  assign upper = din[IN_W-1:OUT_W-1];
  assign clamp = ~((&upper) | ~(|upper));

  // Pick the rail from the input sign when out of range, otherwise truncate.
  always_comb begin
    dout = din[OUT_W-1:0];
    if (clamp) dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end
endmodule

module two_parallel_serializer #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_y0,
  input  logic [IN_W-1:0]          in_y1,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     sat_flag,
  input  logic                     sat_clr
);
  localparam int NUM_LANES = 2;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [NUM_LANES-1:0][IN_W-1:0]  in_pair;
  logic [NUM_LANES-1:0][OUT_W-1:0] sat_pair;
  logic [NUM_LANES-1:0]            clamp;

  logic [DEPTH-1:0][NUM_LANES-1:0][OUT_W-1:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          sel;
  logic          push, pop_pair;

  assign in_pair = {in_y1, in_y0};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    two_parallel_serializer_sat #(.IN_W(IN_W), .OUT_W(OUT_W)) u_sat (
      .din   (in_pair[g]),
      .dout  (sat_pair[g]),
      .clamp (clamp[g])
    );
  end

  // Ready depends on registered level only, so a full FIFO never pushes,
  // even when the head pair is leaving this same cycle.
  assign in_ready  = (level < LW'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid & in_ready;
  assign pop_pair  = out_valid & out_ready & sel;
  assign out_data  = out_valid ? mem[rd_ptr][sel] : '0;

  // Pair storage; contents are don't-care while not counted by level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sat_pair;
  end

  // Pointers, occupancy, output phase and sticky saturation flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      sel      <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + AW'(1);
      if (pop_pair) rd_ptr <= rd_ptr + AW'(1);
      if (out_valid && out_ready) sel <= ~sel;
      case ({push, pop_pair})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (push && (|clamp)) sat_flag <= 1'b1;
      else if (sat_clr)     sat_flag <= 1'b0;
    end
  end
endmodule

// File: tb/tb_two_parallel_serializer.sv
// Bench for two_parallel_serializer: table vectors, directed corner sequences
// and random traffic, all checked against a sample-queue reference model.
module tb_two_parallel_serializer;
  localparam int IN_W  = 64;
  localparam int OUT_W = 16;
  localparam int DEPTH = 4;
  localparam longint MAXO = (longint'(1) <<< (OUT_W-1)) - 1;
  localparam longint MINO = -(longint'(1) <<< (OUT_W-1));

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [IN_W-1:0]        in_y0 = '0;
  logic [IN_W-1:0]        in_y1 = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [OUT_W-1:0]       out_data;
  logic [$clog2(DEPTH):0] level;
  logic                   sat_flag;
  logic                   sat_clr = 1'b0;

  two_parallel_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_y0(in_y0), .in_y1(in_y1), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .level(level), .sat_flag(sat_flag), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the stream of samples still to be emitted, in order.
  longint q[$];
  bit     m_sat = 1'b0;

  typedef struct {
    longint y0, y1, e0, e1;
    bit     es;
  } vec_t;
  vec_t tbl[8];

  function automatic longint sat(longint v);
    if (v > MAXO) return MAXO;
    if (v < MINO) return MINO;
    return v;
  endfunction

  // A pair stays stored until both its samples are gone.
  function automatic int m_level();
    return (q.size() + 1) / 2;
  endfunction

  task automatic chk(string name, logic signed [63:0] act, logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(q.size() != 0));
    chk({tag, "_out_data"},  64'($signed(out_data)), (q.size() != 0) ? q[0] : 0);
    chk({tag, "_in_ready"},  64'(in_ready), 64'(m_level() < DEPTH));
    chk({tag, "_level"},     64'(level), 64'(m_level()));
    chk({tag, "_sat_flag"},  64'(sat_flag), 64'(m_sat));
  endtask

  // One clock: drive, check settled outputs, clock, advance the model.
  task automatic step(bit iv, longint y0, longint y1, bit ordy, bit clr, string tag);
    bit acc, pop;
    in_valid = iv; in_y0 = y0; in_y1 = y1; out_ready = ordy; sat_clr = clr;
    #1 check_outs(tag);
    acc = iv && (m_level() < DEPTH);
    pop = ordy && (q.size() != 0);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) begin q.push_back(sat(y0)); q.push_back(sat(y1)); end
    if (acc && (sat(y0) != y0 || sat(y1) != y1)) m_sat = 1'b1;
    else if (clr) m_sat = 1'b0;
    #1;
  endtask

  task automatic drain(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, "drain");
  endtask

  initial begin
    bit     prev;
    bit     rdy;
    int     c;
    longint kk, n, a, b;

    tbl[0] = '{100, -200, 100, -200, 0};
    tbl[1] = '{40000, -40000, 32767, -32768, 1};
    tbl[2] = '{32767, -32768, 32767, -32768, 0};
    tbl[3] = '{32768, -32769, 32767, -32768, 1};
    tbl[4] = '{64'sh7FFF_FFFF_FFFF_FFFF, 64'sh8000_0000_0000_0000, 32767, -32768, 1};
    tbl[5] = '{-1, 0, -1, 0, 0};
    tbl[6] = '{65535, -65536, 32767, -32768, 1};
    tbl[7] = '{64'sh0000_0100_0000_0001, -5, 32767, -5, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_out_data", 64'(out_data), 0);
    chk("rst_level", 64'(level), 0);
    chk("rst_sat_flag", 64'(sat_flag), 0);
    #2 rst = 1'b1;

    // Table vectors: clear flag, push one pair, read y0 then y1
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 1, "vclr");
      step(1, tbl[i].y0, tbl[i].y1, 0, 0, "vpush");
      chk("vec_y0", 64'($signed(out_data)), tbl[i].e0);
      step(0, 0, 0, 1, 0, "vpop0");
      chk("vec_y1", 64'($signed(out_data)), tbl[i].e1);
      chk("vec_sat", 64'(sat_flag), 64'(tbl[i].es));
      step(0, 0, 0, 1, 0, "vpop1");
      chk("vec_empty", 64'(out_valid), 0);
      chk("vec_level0", 64'(level), 0);
    end

    // Clamping push and clear in the same cycle: set wins
    step(0, 0, 0, 0, 1, "sclr");
    step(1, 40000, 0, 0, 1, "setwin");
    chk("set_wins", 64'(sat_flag), 1);
    drain(2);
    step(0, 0, 0, 0, 1, "sclr2");

    // Full / backpressure
    for (int i = 0; i < 5; i++) step(1, 2*i+1, 2*i+2, 0, 0, "fill");
    chk("full_level", 64'(level), DEPTH);
    chk("full_in_ready", 64'(in_ready), 0);
    c = 0;
    while (c < 12) begin
      rdy = (m_level() < DEPTH);
      step(1, 9, 10, 1, 0, "refill");
      if (rdy) break;
      c++;
    end
    chk("refill_cycle", c, 2);
    drain(12);

    // Sustained streaming
    kk = 0; n = 0; prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rdy = (m_level() < DEPTH);
      step(1, 2*kk, 2*kk+1, 1, 0, "stream");
      if (rdy) kk++;
      chk("stream_data", 64'($signed(out_data)), n);
      n++;
      if (i >= 20) chk("stream_alt", 64'(in_ready), 64'(!prev));
      prev = in_ready;
    end
    drain(10);

    // Stall with sel=1
    step(1, 11, 12, 0, 0, "stpush");
    step(1, 13, 14, 0, 0, "stpush");
    step(0, 0, 0, 1, 0, "stpop");
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, "stall");
      chk("stall_data", 64'($signed(out_data)), 12);
      chk("stall_level", 64'(level), 2);
    end
    drain(5);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) step(1, 20+i, 30+i, 0, 0, "mpush");
    step(0, 0, 0, 1, 0, "mpop");
    chk("pre_rst_level", 64'(level), 3);
    #1 rst = 1'b0;
    #1;
    chk("mrst_out_valid", 64'(out_valid), 0);
    chk("mrst_level", 64'(level), 0);
    chk("mrst_in_ready", 64'(in_ready), 1);
    q.delete();
    m_sat = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    step(1, 7, 8, 1, 0, "mpost");
    chk("mrst_first", 64'($signed(out_data)), 7);
    step(0, 0, 0, 1, 0, "mpost");
    chk("mrst_second", 64'($signed(out_data)), 8);
    drain(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       begin a = longint'($urandom_range(0, 80000)) - 40000; b = longint'($urandom_range(0, 80000)) - 40000; end
        1:       begin a = longint'({$urandom(), $urandom()}); b = longint'({$urandom(), $urandom()}); end
        default: begin a = longint'($urandom_range(0, 2000)) - 1000; b = longint'($urandom_range(0, 2000)) - 1000; end
      endcase
      step(bit'($urandom_range(0, 1)), a, b, bit'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), "rand");
    end
    drain(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
